// File: rtl/nvme_pkg.sv
// Shared constants and types for the NVMe submission-queue write path.
package nvme_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SQ_WR   = 3'd1,
    SQ_RESP = 3'd2,
    DB_WR   = 3'd3,
    DB_RESP = 3'd4
  } sq_state_e;

  localparam int          SQ_DEPTH        = 16;
  localparam int          ENTRY_BYTES     = 64;
  localparam int          ENTRY_SHIFT     = $clog2(ENTRY_BYTES);
  localparam logic [2:0]  AXI_SIZE_64B    = 3'b110;
  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [31:0] DB_ADDR_DEFAULT = 32'h0000_1008;
endpackage

// File: rtl/nvme_sq_submit_ctrl_if.sv
// Write-only AXI4 (SQ memory) and AXI-Lite (doorbell) channel bundles.
interface nvme_sq_axi_if #(parameter int ADDR_W = 10, parameter int DATA_W = 512);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;
  logic              bvalid, bready;
  logic [1:0]        bresp;

  modport master (output awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
                  input  awready, wready, bvalid, bresp);
  modport slave  (input  awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
                  output awready, wready, bvalid, bresp);
endinterface

interface nvme_nl_axil_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;

  modport master (output awvalid, awaddr, wvalid, wdata, wstrb, bready,
                  input  awready, wready, bvalid, bresp);
  modport slave  (input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
                  output awready, wready, bvalid, bresp);
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; priority flips to the other side after each accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic pri;  // 1: requester 1 wins a tie

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = pri ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         pri <= 1'b0;
    else if (accept) pri <= gnt[0];
  end
endmodule

// File: rtl/nvme_sq_submit_ctrl.sv
// Accepts SQ entries from two requesters, writes them into the SQ ring over AXI4,
// then rings the tail doorbell over AXI-Lite.
module nvme_sq_submit_ctrl
  import nvme_pkg::*;
#(
  parameter int          SQ_ADDR_WIDTH = 10,
  parameter int          SQ_DATA_WIDTH = 512,
  parameter int          NL_ADDR_WIDTH = 32,
  parameter int          NL_DATA_WIDTH = 32,
  parameter int          SQ_DEPTH      = nvme_pkg::SQ_DEPTH,
  parameter logic [31:0] DB_ADDR       = DB_ADDR_DEFAULT,
  localparam int         TAIL_W        = $clog2(SQ_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [SQ_DATA_WIDTH-1:0] req_cmd0,
  input  logic [SQ_DATA_WIDTH-1:0] req_cmd1,
  input  logic                     head_valid,
  input  logic [TAIL_W-1:0]        head_in,
  nvme_sq_axi_if.master            sq,
  nvme_nl_axil_if.master           nl,
  output logic [TAIL_W-1:0]        tail,
  output logic                     busy,
  output logic                     err
);
  sq_state_e                state, state_d;
  logic [TAIL_W-1:0]        head;
  logic [15:0]              cid;
  logic [SQ_DATA_WIDTH-1:0] entry, entry_d;
  logic [1:0]               gnt;
  logic                     full, accept;
  logic                     aw_done, w_done, aw_hs, w_hs;

  assign full   = (tail + TAIL_W'(1)) == head;
  assign req_ready = (state == IDLE && !full) ? gnt : 2'b00;
  assign accept = |(req_valid & req_ready);
  assign busy   = (state != IDLE);

  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req_valid), .accept(accept), .gnt(gnt));

  always_comb begin
    entry_d = req_ready[1] ? req_cmd1 : req_cmd0;
    entry_d[31:16] = cid;
  end

  // Payloads are constant for the life of a state, so they hold while valid waits.
  assign sq.awaddr  = SQ_ADDR_WIDTH'({tail, {ENTRY_SHIFT{1'b0}}});
  assign sq.awlen   = 8'd0;
  assign sq.awsize  = AXI_SIZE_64B;
  assign sq.awburst = AXI_BURST_INCR;
  assign sq.wdata   = entry;
  assign sq.wstrb   = '1;
  assign sq.wlast   = 1'b1;
  assign nl.awaddr  = NL_ADDR_WIDTH'(DB_ADDR);
  assign nl.wdata   = NL_DATA_WIDTH'(tail);
  assign nl.wstrb   = '1;

  assign aw_hs = (sq.awvalid && sq.awready) || (nl.awvalid && nl.awready);
  assign w_hs  = (sq.wvalid && sq.wready) || (nl.wvalid && nl.wready);

  always_comb begin
    state_d    = state;
    sq.awvalid = 1'b0;
    sq.wvalid  = 1'b0;
    sq.bready  = 1'b0;
    nl.awvalid = 1'b0;
    nl.wvalid  = 1'b0;
    nl.bready  = 1'b0;
    case (state)
      IDLE: if (accept) state_d = SQ_WR;
      SQ_WR: begin
        sq.awvalid = !aw_done;
        sq.wvalid  = !w_done;
        if ((aw_done || sq.awready) && (w_done || sq.wready)) state_d = SQ_RESP;
      end
      SQ_RESP: begin
        sq.bready = 1'b1;
        if (sq.bvalid) state_d = (sq.bresp == AXI_RESP_OKAY) ? DB_WR : IDLE;
      end
      DB_WR: begin
        nl.awvalid = !aw_done;
        nl.wvalid  = !w_done;
        if ((aw_done || nl.awready) && (w_done || nl.wready)) state_d = DB_RESP;
      end
      DB_RESP: begin
        nl.bready = 1'b1;
        if (nl.bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // AW/W may complete in either order; remember which side is finished.
  always_ff @(posedge clk) begin
    if (rst || state_d != state) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail <= '0;
      head <= '0;
      cid  <= '0;
      err  <= 1'b0;
    end else begin
      if (head_valid) head <= head_in;
      if (accept)     cid  <= cid + 16'd1;
      if (state == SQ_RESP && sq.bvalid) begin
        if (sq.bresp == AXI_RESP_OKAY) tail <= tail + TAIL_W'(1);
        else                           err  <= 1'b1;
      end
      if (state == DB_RESP && nl.bvalid && nl.bresp != AXI_RESP_OKAY) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) entry <= entry_d;
  end
endmodule

// File: tb/tb_nvme_sq_submit_ctrl.sv
// Directed bench: transaction table plus hand sequences for full, AW stall and mid-flight reset.
module tb_nvme_sq_submit_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [511:0] req_cmd0 = {16{32'h1111_AAAA}};
  logic [511:0] req_cmd1 = {16{32'h2222_BBBB}};
  logic         head_valid = 1'b0;
  logic [3:0]   head_in = 4'd0;
  logic [3:0]   tail;
  logic         busy, err;

  logic sq_aw_rdy = 1'b1, sq_w_rdy = 1'b1, nl_aw_rdy = 1'b1, nl_w_rdy = 1'b1;
  logic [1:0] sq_bresp_val = 2'b00, nl_bresp_val = 2'b00;

  nvme_sq_axi_if  #(.ADDR_W(10), .DATA_W(512)) sq_if();
  nvme_nl_axil_if #(.ADDR_W(32), .DATA_W(32))  nl_if();

  nvme_sq_submit_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .head_valid(head_valid), .head_in(head_in),
    .sq(sq_if), .nl(nl_if), .tail(tail), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Slave models: B response one cycle after both AW and W have completed.
  assign sq_if.awready = sq_aw_rdy;
  assign sq_if.wready  = sq_w_rdy;
  assign sq_if.bresp   = sq_bresp_val;
  assign nl_if.awready = nl_aw_rdy;
  assign nl_if.wready  = nl_w_rdy;
  assign nl_if.bresp   = nl_bresp_val;

  logic sq_aw_hs, sq_w_hs, nl_aw_hs, nl_w_hs;
  logic sq_aws, sq_ws, nl_aws, nl_ws;
  assign sq_aw_hs = sq_if.awvalid & sq_if.awready;
  assign sq_w_hs  = sq_if.wvalid  & sq_if.wready;
  assign nl_aw_hs = nl_if.awvalid & nl_if.awready;
  assign nl_w_hs  = nl_if.wvalid  & nl_if.wready;

  always @(posedge clk) begin
    if (rst) begin
      sq_aws <= 1'b0; sq_ws <= 1'b0; sq_if.bvalid <= 1'b0;
      nl_aws <= 1'b0; nl_ws <= 1'b0; nl_if.bvalid <= 1'b0;
    end else begin
      if (sq_if.bvalid && sq_if.bready) sq_if.bvalid <= 1'b0;
      if ((sq_aws | sq_aw_hs) && (sq_ws | sq_w_hs)) begin
        sq_if.bvalid <= 1'b1; sq_aws <= 1'b0; sq_ws <= 1'b0;
      end else begin
        sq_aws <= sq_aws | sq_aw_hs; sq_ws <= sq_ws | sq_w_hs;
      end
      if (nl_if.bvalid && nl_if.bready) nl_if.bvalid <= 1'b0;
      if ((nl_aws | nl_aw_hs) && (nl_ws | nl_w_hs)) begin
        nl_if.bvalid <= 1'b1; nl_aws <= 1'b0; nl_ws <= 1'b0;
      end else begin
        nl_aws <= nl_aws | nl_aw_hs; nl_ws <= nl_ws | nl_w_hs;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at negedge, record handshakes that complete on the coming posedge.
  bit          acc_gnt_q[$];
  int          acc_cyc_q[$];
  logic [15:0] cid_q[$];
  logic [9:0]  addr_q[$];
  logic [31:0] db_q[$];
  int          nl_aw_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (|(req_valid & req_ready)) begin acc_gnt_q.push_back(req_ready[1]); acc_cyc_q.push_back(cyc); end
      if (sq_w_hs)  cid_q.push_back(sq_if.wdata[31:16]);
      if (sq_aw_hs) addr_q.push_back(sq_if.awaddr);
      if (nl_w_hs)  db_q.push_back(nl_if.wdata);
      if (nl_if.awvalid) nl_aw_cnt++;
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    acc_gnt_q.delete(); acc_cyc_q.delete(); cid_q.delete(); addr_q.delete(); db_q.delete();
    nl_aw_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; head_valid = 1'b0; head_in = 4'd0;
    sq_aw_rdy = 1'b1; sq_w_rdy = 1'b1; nl_aw_rdy = 1'b1; nl_w_rdy = 1'b1;
    sq_bresp_val = 2'b00; nl_bresp_val = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_accept(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_fail++; $display("FAIL %s: accept timeout", nm); end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_fail++; $display("FAIL %s: idle timeout", nm); end
  endtask

  typedef struct {
    logic [1:0] v;
    logic [1:0] bresp;
    int gnt, cid, addr, tl, er, db_cnt, db;
  } vec_t;
  vec_t tv[6];

  initial begin
    tv[0] = '{2'b01, 2'b00, 0, 0, 'h000, 1, 0, 1, 1};
    tv[1] = '{2'b10, 2'b00, 1, 1, 'h040, 2, 0, 1, 2};
    tv[2] = '{2'b11, 2'b00, 0, 2, 'h080, 3, 0, 1, 3};
    tv[3] = '{2'b11, 2'b00, 1, 3, 'h0C0, 4, 0, 1, 4};
    tv[4] = '{2'b01, 2'b10, 0, 4, 'h100, 4, 1, 0, 0};
    tv[5] = '{2'b10, 2'b00, 1, 5, 'h100, 5, 1, 1, 5};

    do_reset();
    @(negedge clk);
    chk("rst_tail", tail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_valids", {sq_if.awvalid, sq_if.wvalid, nl_if.awvalid, nl_if.wvalid}, 0);

    // Table of single transactions from reset
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      clear_mon();
      sq_bresp_val = tv[i].bresp;
      req_valid = tv[i].v;
      wait_accept("tbl");
      req_valid = 2'b00;
      wait_idle("tbl");
      chk($sformatf("tbl%0d_gnt", i), acc_gnt_q.size() == 1 ? 64'(acc_gnt_q[0]) : 64'hdead, tv[i].gnt);
      chk($sformatf("tbl%0d_cid", i), cid_q.size() == 1 ? 64'(cid_q[0]) : 64'hdead, tv[i].cid);
      chk($sformatf("tbl%0d_addr", i), addr_q.size() == 1 ? 64'(addr_q[0]) : 64'hdead, tv[i].addr);
      chk($sformatf("tbl%0d_tail", i), tail, tv[i].tl);
      chk($sformatf("tbl%0d_err", i), err, tv[i].er);
      chk($sformatf("tbl%0d_nlaw", i), nl_aw_cnt, tv[i].db_cnt);
      if (tv[i].db_cnt == 1)
        chk($sformatf("tbl%0d_db", i), db_q.size() == 1 ? 64'(db_q[0]) : 64'hdead, tv[i].db);
    end
    sq_bresp_val = 2'b00;

    // Both requesters valid continuously: alternating grants, 5-cycle accept spacing
    do_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (acc_gnt_q.size() >= 4) break;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle("alt");
    chk("alt_count", acc_gnt_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_gnt_q.size()) chk($sformatf("alt_gnt%0d", i), acc_gnt_q[i], i % 2);
      if (i < cid_q.size())     chk($sformatf("alt_cid%0d", i), cid_q[i], i);
      if (i > 0 && i < acc_cyc_q.size())
        chk($sformatf("alt_lat%0d", i), acc_cyc_q[i] - acc_cyc_q[i-1], 5);
    end
    chk("alt_tail", tail, 4);

    // Fill to full with head=0, then release with head_in=4
    do_reset();
    req_valid = 2'b01;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (tail == 4'd15 && !busy) begin ok = 1'b1; break; end
      end
      chk("full_reached", ok, 1);
    end
    chk("full_tail", tail, 15);
    chk("full_accepts", acc_gnt_q.size(), 15);
    begin
      int rdy_seen = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) rdy_seen++;
      end
      chk("full_ready_held0", rdy_seen, 0);
    end
    @(posedge clk); #1;
    head_valid = 1'b1; head_in = 4'd4;
    @(negedge clk);
    chk("full_head_not_yet", req_ready, 2'b00);
    @(posedge clk); #1;
    head_valid = 1'b0;
    @(negedge clk);
    chk("full_ready_resume", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle("full");
    chk("wrap_addr", addr_q.size() == 16 ? 64'(addr_q[15]) : 64'hdead, 'h3C0);
    chk("wrap_tail", tail, 0);
    chk("wrap_db", db_q.size() == 16 ? 64'(db_q[15]) : 64'hdead, 0);

    // AW ready held off for three cycles, W accepted immediately
    do_reset();
    sq_aw_rdy = 1'b0;
    req_valid = 2'b01;
    wait_accept("awd");
    req_valid = 2'b00;
    @(negedge clk);
    chk("awd_c1_valids", {sq_if.awvalid, sq_if.wvalid}, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("awd_c2_valids", {sq_if.awvalid, sq_if.wvalid}, 2'b10);
    chk("awd_c2_addr", sq_if.awaddr, 0);
    chk("awd_c2_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("awd_c3_valids", {sq_if.awvalid, sq_if.wvalid, nl_if.awvalid}, 3'b100);
    chk("awd_c3_addr", sq_if.awaddr, 0);
    @(posedge clk); #1;
    sq_aw_rdy = 1'b1;
    wait_idle("awd");
    chk("awd_w_hs", cid_q.size(), 1);
    chk("awd_tail", tail, 1);
    chk("awd_db", db_q.size() == 1 ? 64'(db_q[0]) : 64'hdead, 1);

    // Reset while stalled in doorbell write
    do_reset();
    sq_bresp_val = 2'b10;
    req_valid = 2'b01;
    wait_accept("rstm_err");
    req_valid = 2'b00;
    wait_idle("rstm_err");
    chk("rstm_err_set", err, 1);
    sq_bresp_val = 2'b00;
    nl_aw_rdy = 1'b0; nl_w_rdy = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b01;
    wait_accept("rstm");
    req_valid = 2'b00;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (nl_if.awvalid) begin ok = 1'b1; break; end
      end
      chk("rstm_in_dbwr", ok, 1);
    end
    chk("rstm_pre_tail", tail, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nl_aw_rdy = 1'b1; nl_w_rdy = 1'b1;
    @(negedge clk);
    chk("rstm_valids", {sq_if.awvalid, sq_if.wvalid, nl_if.awvalid, nl_if.wvalid}, 0);
    chk("rstm_tail", tail, 0);
    chk("rstm_err", err, 0);
    chk("rstm_busy", busy, 0);
    clear_mon();
    @(posedge clk); #1;
    req_valid = 2'b01;
    wait_accept("rstm_post");
    req_valid = 2'b00;
    wait_idle("rstm_post");
    chk("rstm_cid0", cid_q.size() == 1 ? 64'(cid_q[0]) : 64'hdead, 0);
    chk("rstm_post_tail", tail, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
